// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
// Contents: controller state encoding and the maximum supported operand width.
package serial_adder_pkg;

   localparam int unsigned WIDTH_MAX = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder cell used by serial_adder.
// Ports:
//   co - carry out
//   s  - sum bit
//   ci - carry in
//   x  - operand bit x
//   y  - operand bit y
module fa (
   output logic co,
   output logic s,
   input  logic ci,
   input  logic x,
   input  logic y
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder evaluation per clock, LSB first.
// Operands are taken over a valid/ready handshake, the result is returned over
// a second valid/ready handshake.
// Optional macro SERIAL_ADDER_OVF_EN adds the out_ovf signed-overflow output.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - operand handshake (in_ready high only while idle)
//   in_x, in_y, in_ci   - operands and carry-in
//   out_valid/out_ready - result handshake
//   out_sum, out_co     - sum and final carry-out, held after the handshake
//   out_ovf             - signed overflow (SERIAL_ADDER_OVF_EN only)
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_x,
   input  logic [WIDTH-1:0] in_y,
   input  logic             in_ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             out_ovf,
`endif
   output logic             out_co
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t             state;
   logic [WIDTH-1:0]   x_sh;
   logic [WIDTH-1:0]   y_sh;
   logic [WIDTH-1:0]   sum_sh;
   logic               carry;
   logic [CNT_W-1:0]   count;
   logic               fa_s;
   logic               fa_co;
   logic [WIDTH-1:0]   sum_next;

   // The only arithmetic: one bit of each operand per clock.
   fa u_fa (
      .co (fa_co),
      .s  (fa_s),
      .ci (carry),
      .x  (x_sh[0]),
      .y  (y_sh[0])
   );

   // New sum bit enters at the MSB; written as a shift so WIDTH=1 stays legal.
   assign sum_next = (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

   // Control FSM, shift registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         x_sh      <= '0;
         y_sh      <= '0;
         sum_sh    <= '0;
         carry     <= 1'b0;
         count     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_co    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         out_ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  x_sh     <= in_x;
                  y_sh     <= in_y;
                  carry    <= in_ci;
                  count    <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               x_sh   <= x_sh >> 1;
               y_sh   <= y_sh >> 1;
               sum_sh <= sum_next;
               carry  <= fa_co;
               if (count == LAST_BIT) begin
                  // Final bit: capture the complete result straight from the cell.
                  out_sum   <= sum_next;
                  out_co    <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                  // carry still holds the carry into the MSB on this edge.
                  out_ovf   <= carry ^ fa_co;
`endif
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed handshake/latency/reset cases
// on an 8-bit instance plus random sweeps at widths 1, 8 and 32 against an
// arithmetic reference model.
module tb_serial_adder;
   import serial_adder_pkg::*;

   localparam int unsigned W8 = 8;

   typedef struct packed {
      logic        ovf;
      logic        co;
      logic [31:0] sum;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // 8-bit instance
   logic       a_in_valid, a_in_ready, a_in_ci, a_out_valid, a_out_ready, a_out_co;
   logic [7:0] a_in_x, a_in_y, a_out_sum;
`ifdef SERIAL_ADDER_OVF_EN
   logic       a_out_ovf;
`endif

   // Shared stimulus for the 1-bit and 32-bit instances
   logic        s_in_valid, s_out_ready, s_in_ci;
   logic [31:0] s_in_x, s_in_y;
   logic        n_in_ready, n_out_valid, n_out_co;
   logic [0:0]  n_out_sum;
   logic        w_in_ready, w_out_valid, w_out_co;
   logic [31:0] w_out_sum;
`ifdef SERIAL_ADDER_OVF_EN
   logic        n_out_ovf, w_out_ovf;
`endif

   serial_adder #(.WIDTH(W8)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_x(a_in_x), .in_y(a_in_y), .in_ci(a_in_ci),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_sum(a_out_sum),
`ifdef SERIAL_ADDER_OVF_EN
      .out_ovf(a_out_ovf),
`endif
      .out_co(a_out_co)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid), .in_ready(n_in_ready),
      .in_x(s_in_x[0:0]), .in_y(s_in_y[0:0]), .in_ci(s_in_ci),
      .out_valid(n_out_valid), .out_ready(s_out_ready),
      .out_sum(n_out_sum),
`ifdef SERIAL_ADDER_OVF_EN
      .out_ovf(n_out_ovf),
`endif
      .out_co(n_out_co)
   );

   serial_adder #(.WIDTH(WIDTH_MAX)) u_dut32 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid), .in_ready(w_in_ready),
      .in_x(s_in_x), .in_y(s_in_y), .in_ci(s_in_ci),
      .out_valid(w_out_valid), .out_ready(s_out_ready),
      .out_sum(w_out_sum),
`ifdef SERIAL_ADDER_OVF_EN
      .out_ovf(w_out_ovf),
`endif
      .out_co(w_out_co)
   );

   // Results observed on completed handshakes of the 1-bit and 32-bit instances.
   res_t obs_n[$];
   res_t obs_w[$];

   always @(negedge clk) begin
      res_t r;
      if (n_out_valid && s_out_ready) begin
         r.co  = n_out_co;
         r.sum = 32'(n_out_sum);
`ifdef SERIAL_ADDER_OVF_EN
         r.ovf = n_out_ovf;
`else
         r.ovf = 1'b0;
`endif
         obs_n.push_back(r);
      end
      if (w_out_valid && s_out_ready) begin
         r.co  = w_out_co;
         r.sum = w_out_sum;
`ifdef SERIAL_ADDER_OVF_EN
         r.ovf = w_out_ovf;
`else
         r.ovf = 1'b0;
`endif
         obs_w.push_back(r);
      end
   end

   // Reference: plain integer addition of w-bit operands, signed-range overflow.
   function automatic res_t ref_res(input int unsigned w, input logic [31:0] x,
                                    input logic [31:0] y, input logic ci);
      res_t r;
      longint unsigned m, ux, uy, tot;
      longint sx, sy, st, lim;
      m   = (64'd1 << w) - 64'd1;
      ux  = 64'(x) & m;
      uy  = 64'(y) & m;
      tot = ux + uy + (ci ? 64'd1 : 64'd0);
      r.sum = 32'(tot & m);
      r.co  = ((tot >> w) & 64'd1) != 64'd0;
      lim = longint'(64'd1 << (w - 1));
      sx  = (ux >= (64'd1 << (w - 1))) ? longint'(ux) - 2 * lim : longint'(ux);
      sy  = (uy >= (64'd1 << (w - 1))) ? longint'(uy) - 2 * lim : longint'(uy);
      st  = sx + sy + (ci ? 64'sd1 : 64'sd0);
      r.ovf = (st >= lim) || (st < -lim);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one operation on the 8-bit instance with out_ready high and returns
   // what it produced; lat counts edges from accept to out_valid.
   task automatic run_op8(input logic [7:0] x, input logic [7:0] y, input logic ci,
                          output logic [7:0] sum, output logic co, output logic ovf,
                          output int lat, output logic held, output bit ok);
      int n;
      n = 0;
      sum = '0; co = 1'b0; ovf = 1'b0; lat = 0; held = 1'b0; ok = 1'b0;
      while (!a_in_ready && n < 50) begin
         step();
         n++;
      end
      if (!a_in_ready) return;
      a_in_x = x; a_in_y = y; a_in_ci = ci; a_out_ready = 1'b1; a_in_valid = 1'b1;
      step();
      a_in_valid = 1'b0;
      for (int k = 1; k <= 64; k++) begin
         step();
         if (a_out_valid) begin
            lat = k;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) return;
      sum = a_out_sum;
      co  = a_out_co;
`ifdef SERIAL_ADDER_OVF_EN
      ovf = a_out_ovf;
`endif
      step();
      held = a_out_valid;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if ({a_out_valid, a_out_co} !== 2'b00) begin
         failures++;
         $display("FAIL reset_outputs: out_valid,out_co=%b required 00", {a_out_valid, a_out_co});
      end
      checks++;
      if ({n_out_valid, w_out_valid} !== 2'b00) begin
         failures++;
         $display("FAIL reset_nw_valid: got %b required 00", {n_out_valid, w_out_valid});
      end
      rst_n = 1'b1;
      step();
      checks++;
      if ({a_in_ready, n_in_ready, w_in_ready} !== 3'b111) begin
         failures++;
         $display("FAIL reset_in_ready: got %b required 111", {a_in_ready, n_in_ready, w_in_ready});
      end
   endtask

   task automatic test_basic();
      logic [7:0] s; logic co, ov, held; int lat; bit ok;
      run_op8(8'h03, 8'h05, 1'b0, s, co, ov, lat, held, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL basic_timeout: no out_valid within 64 edges");
      end
      checks++;
      if (lat !== 8) begin
         failures++;
         $display("FAIL basic_latency: got %0d required 8", lat);
      end
      checks++;
      if ({co, s} !== 9'h008) begin
         failures++;
         $display("FAIL basic_sum: co,sum=%h required 008", {co, s});
      end
      checks++;
      if (held !== 1'b0) begin
         failures++;
         $display("FAIL basic_valid_width: out_valid=%b after handshake required 0", held);
      end
   endtask

   task automatic test_carry();
      logic [7:0] s; logic co, ov, held; int lat; bit ok;
      run_op8(8'hFF, 8'h01, 1'b0, s, co, ov, lat, held, ok);
      checks++;
      if (!ok || {co, s} !== 9'h100) begin
         failures++;
         $display("FAIL carry_ff_01: ok=%b co,sum=%h required 100", ok, {co, s});
      end
      run_op8(8'hFF, 8'hFF, 1'b1, s, co, ov, lat, held, ok);
      checks++;
      if (!ok || {co, s} !== 9'h1FF) begin
         failures++;
         $display("FAIL carry_ff_ff_1: ok=%b co,sum=%h required 1ff", ok, {co, s});
      end
   endtask

   task automatic test_backpressure();
      res_t e; logic [7:0] x, y; logic ci; int seen;
      x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom_range(0, 1));
      e = ref_res(W8, 32'(x), 32'(y), ci);
      a_out_ready = 1'b0;
      a_in_x = x; a_in_y = y; a_in_ci = ci; a_in_valid = 1'b1;
      step();
      a_in_x = ~x;
      for (int k = 1; k <= 8; k++) begin
         a_in_valid = (k == 3);
         step();
         if (k < 8) begin
            checks++;
            if ({a_in_ready, a_out_valid} !== 2'b00) begin
               failures++;
               $display("FAIL bp_run_%0d: in_ready,out_valid=%b required 00", k, {a_in_ready, a_out_valid});
            end
         end
      end
      for (int k = 1; k <= 5; k++) begin
         a_in_valid = (k == 2);
         step();
         checks++;
         if ({a_out_valid, a_in_ready, a_out_co, a_out_sum} !== {2'b10, e.co, e.sum[7:0]}) begin
            failures++;
            $display("FAIL bp_hold_%0d: valid,ready,co,sum=%b,%b,%b,%h required 1,0,%b,%h",
                     k, a_out_valid, a_in_ready, a_out_co, a_out_sum, e.co, e.sum[7:0]);
         end
      end
      a_in_valid = 1'b0;
      a_out_ready = 1'b1;
      step();
      checks++;
      if ({a_out_valid, a_in_ready} !== 2'b01) begin
         failures++;
         $display("FAIL bp_release: out_valid,in_ready=%b required 01", {a_out_valid, a_in_ready});
      end
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (a_out_valid || !a_in_ready) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL bp_no_second_result: %0d busy/valid cycles required 0", seen);
      end
      checks++;
      if ({a_out_co, a_out_sum} !== {e.co, e.sum[7:0]}) begin
         failures++;
         $display("FAIL bp_result_held: co,sum=%b,%h required %b,%h", a_out_co, a_out_sum, e.co, e.sum[7:0]);
      end
      a_in_x = x;
   endtask

   task automatic test_reset_mid_run();
      logic [7:0] s; logic co, ov, held; int lat, seen; bit ok;
      a_out_ready = 1'b1;
      a_in_x = 8'($urandom); a_in_y = 8'($urandom); a_in_ci = 1'b1; a_in_valid = 1'b1;
      step();
      a_in_valid = 1'b0;
      step(); step(); step();
      rst_n = 1'b0;
      #1;
      checks++;
      if (a_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_run_valid: out_valid=%b required 0", a_out_valid);
      end
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if (a_in_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_run_in_ready: got %b required 1", a_in_ready);
      end
      seen = 0;
      for (int k = 0; k < int'(W8) + 2; k++) begin
         step();
         if (a_out_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL rst_run_no_result: %0d valid cycles required 0", seen);
      end
      run_op8(8'h10, 8'h20, 1'b0, s, co, ov, lat, held, ok);
      checks++;
      if (!ok || {co, s} !== 9'h030) begin
         failures++;
         $display("FAIL rst_run_next_op: ok=%b co,sum=%h required 030", ok, {co, s});
      end
      // Reset while a result is waiting must drop out_valid without a clock.
      a_out_ready = 1'b0;
      a_in_valid = 1'b1;
      step();
      a_in_valid = 1'b0;
      for (int k = 0; k < int'(W8); k++) step();
      checks++;
      if (a_out_valid !== 1'b1) begin
         failures++;
         $display("FAIL rst_done_setup: out_valid=%b required 1", a_out_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (a_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_done_async: out_valid=%b required 0", a_out_valid);
      end
      step();
      rst_n = 1'b1;
      step();
      a_out_ready = 1'b1;
      checks++;
      if ({a_in_ready, a_out_valid} !== 2'b10) begin
         failures++;
         $display("FAIL rst_done_release: in_ready,out_valid=%b required 10", {a_in_ready, a_out_valid});
      end
   endtask

   task automatic test_back_to_back();
      res_t exp_q[$];
      res_t e;
      int acc[$];
      int cyc, results;
      bit acc_now;
      cyc = 0;
      results = 0;
      a_out_ready = 1'b1;
      a_in_x = 8'($urandom); a_in_y = 8'($urandom); a_in_ci = 1'($urandom_range(0, 1));
      a_in_valid = 1'b1;
      while (results < 4 && cyc < 200) begin
         acc_now = a_in_valid && a_in_ready;
         if (acc_now) begin
            exp_q.push_back(ref_res(W8, 32'(a_in_x), 32'(a_in_y), a_in_ci));
            acc.push_back(cyc);
         end
         if (a_out_valid && a_out_ready) begin
            results++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL b2b_unexpected: result %h with no operation pending", a_out_sum);
            end else begin
               e = exp_q.pop_front();
`ifdef SERIAL_ADDER_OVF_EN
               if ({a_out_ovf, a_out_co, a_out_sum} !== {e.ovf, e.co, e.sum[7:0]}) begin
                  failures++;
                  $display("FAIL b2b_result_%0d: ovf,co,sum=%b,%b,%h required %b,%b,%h", results,
                           a_out_ovf, a_out_co, a_out_sum, e.ovf, e.co, e.sum[7:0]);
               end
`else
               if ({a_out_co, a_out_sum} !== {e.co, e.sum[7:0]}) begin
                  failures++;
                  $display("FAIL b2b_result_%0d: co,sum=%b,%h required %b,%h", results,
                           a_out_co, a_out_sum, e.co, e.sum[7:0]);
               end
`endif
            end
         end
         step();
         cyc++;
         if (acc_now) begin
            a_in_x = 8'($urandom); a_in_y = 8'($urandom); a_in_ci = 1'($urandom_range(0, 1));
         end
      end
      a_in_valid = 1'b0;
      checks++;
      if (results < 4) begin
         failures++;
         $display("FAIL b2b_timeout: %0d results in %0d cycles required 4", results, cyc);
      end
      for (int i = 0; i < 3 && i + 1 < acc.size(); i++) begin
         checks++;
         if (acc[i+1] - acc[i] !== int'(W8) + 2) begin
            failures++;
            $display("FAIL b2b_spacing_%0d: %0d cycles required %0d", i, acc[i+1] - acc[i], W8 + 2);
         end
      end
      step();
      step();
   endtask

`ifdef SERIAL_ADDER_OVF_EN
   task automatic test_ovf();
      logic [7:0] s; logic co, ov, held; int lat; bit ok;
      run_op8(8'h7F, 8'h01, 1'b0, s, co, ov, lat, held, ok);
      checks++;
      if (!ok || {ov, co, s} !== {2'b10, 8'h80}) begin
         failures++;
         $display("FAIL ovf_7f_01: ovf,co,sum=%b,%b,%h required 1,0,80", ov, co, s);
      end
      run_op8(8'h80, 8'h80, 1'b0, s, co, ov, lat, held, ok);
      checks++;
      if (!ok || {ov, co, s} !== {2'b11, 8'h00}) begin
         failures++;
         $display("FAIL ovf_80_80: ovf,co,sum=%b,%b,%h required 1,1,00", ov, co, s);
      end
      run_op8(8'h03, 8'h05, 1'b0, s, co, ov, lat, held, ok);
      checks++;
      if (!ok || ov !== 1'b0) begin
         failures++;
         $display("FAIL ovf_03_05: ovf=%b required 0", ov);
      end
   endtask
`endif

   task automatic test_sweep8();
      logic [7:0] x, y, s; logic ci, co, ov, held; int lat; bit ok; res_t e;
      for (int i = 0; i < 1000; i++) begin
         x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom_range(0, 1));
         e = ref_res(W8, 32'(x), 32'(y), ci);
         run_op8(x, y, ci, s, co, ov, lat, held, ok);
         checks++;
`ifdef SERIAL_ADDER_OVF_EN
         if (!ok || lat !== 8 || {ov, co, s} !== {e.ovf, e.co, e.sum[7:0]}) begin
            failures++;
            $display("FAIL sweep8 %h+%h+%b: ok=%b lat=%0d ovf,co,sum=%b,%b,%h required 8 %b,%b,%h",
                     x, y, ci, ok, lat, ov, co, s, e.ovf, e.co, e.sum[7:0]);
         end
`else
         if (!ok || lat !== 8 || {co, s} !== {e.co, e.sum[7:0]}) begin
            failures++;
            $display("FAIL sweep8 %h+%h+%b: ok=%b lat=%0d co,sum=%b,%h required 8 %b,%h",
                     x, y, ci, ok, lat, co, s, e.co, e.sum[7:0]);
         end
`endif
      end
   endtask

   task automatic test_sweep_narrow_wide();
      res_t en, ew, on, ow;
      int n;
      s_out_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         n = 0;
         while (!(n_in_ready && w_in_ready) && n < 80) begin
            step();
            n++;
         end
         if (!(n_in_ready && w_in_ready)) begin
            checks++;
            failures++;
            $display("FAIL sweep_nw_ready: in_ready w1=%b w32=%b required 1 1", n_in_ready, w_in_ready);
            return;
         end
         s_in_x = $urandom; s_in_y = $urandom; s_in_ci = 1'($urandom_range(0, 1));
         en = ref_res(1, s_in_x, s_in_y, s_in_ci);
         ew = ref_res(WIDTH_MAX, s_in_x, s_in_y, s_in_ci);
         s_in_valid = 1'b1;
         step();
         s_in_valid = 1'b0;
         n = 0;
         while ((obs_n.size() == 0 || obs_w.size() == 0) && n < 80) begin
            step();
            n++;
         end
         checks++;
         if (obs_n.size() == 0 || obs_w.size() == 0) begin
            failures++;
            $display("FAIL sweep_nw_timeout: results w1=%0d w32=%0d required 1 1", obs_n.size(), obs_w.size());
            return;
         end
         on = obs_n.pop_front();
         ow = obs_w.pop_front();
`ifndef SERIAL_ADDER_OVF_EN
         on.ovf = 1'b0; ow.ovf = 1'b0; en.ovf = 1'b0; ew.ovf = 1'b0;
`endif
         checks++;
         if (on !== en) begin
            failures++;
            $display("FAIL sweep1 %b+%b+%b: ovf,co,sum=%b,%b,%h required %b,%b,%h", s_in_x[0], s_in_y[0],
                     s_in_ci, on.ovf, on.co, on.sum, en.ovf, en.co, en.sum);
         end
         checks++;
         if (ow !== ew) begin
            failures++;
            $display("FAIL sweep32 %h+%h+%b: ovf,co,sum=%b,%b,%h required %b,%b,%h", s_in_x, s_in_y,
                     s_in_ci, ow.ovf, ow.co, ow.sum, ew.ovf, ew.co, ew.sum);
         end
      end
      step();
      step();
      checks++;
      if (obs_n.size() != 0 || obs_w.size() != 0) begin
         failures++;
         $display("FAIL sweep_nw_extra: leftover results w1=%0d w32=%0d required 0 0", obs_n.size(), obs_w.size());
      end
   endtask

   initial begin
      a_in_valid = 1'b0; a_in_ci = 1'b0; a_in_x = '0; a_in_y = '0; a_out_ready = 1'b1;
      s_in_valid = 1'b0; s_in_ci = 1'b0; s_in_x = '0; s_in_y = '0; s_out_ready = 1'b1;
      test_reset();
      test_basic();
      test_carry();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
`ifdef SERIAL_ADDER_OVF_EN
      test_ovf();
`endif
      test_sweep8();
      test_sweep_narrow_wide();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
